regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Issue-stage hazard controller for the 16-entry, 4-bit-addressed register file.
- Tracks in-flight writes per architectural register (R0–R14) with small up/down counters, raised at issue and cleared at writeback.
- Asserts `stall` when an issuing instruction reads a register with a pending write, or when its destination counter is saturated.
- R15 is the externally supplied PC and is never tracked.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  instruction present in issue stage this cycle
- issue_src0  input  4  first source register index
- issue_src0_used  input  1  src0 is actually read
- issue_src1  input  4  second source register index
- issue_src1_used  input  1  src1 is actually read
- issue_dst  input  4  destination register index
- issue_writes  input  1  instruction writes issue_dst
- wb_valid  input  1  writeback stage writes the register file this cycle
- wb_dst  input  4  writeback destination index (same value driven to Destination_select)
- flush  input  1  squash all in-flight instructions
- stall  output  1  hold issue stage; combinational
- issue_accept  output  1  issue_valid & ~stall; combinational
- busy_mask  output  16  bit i = counter i non-zero; bit 15 always 0; registered state
- err_underflow  output  1  sticky: writeback to a register with count 0
- err_overflow  output  1  sticky: increment attempted on saturated counter (defensive; unreachable if stall is honoured)

Behaviour:
- Reset (sync): all counters 0, busy_mask=16'h0000, err_underflow=0, err_overflow=0. Reset overrides flush and all other inputs.
- Tracked set is R0–R14. Any index equal to 15 is ignored as source, destination and wb target: no stall, no count change, no error.
- Effective busy for source s: `cnt[s]!=0`, except when `wb_valid & wb_dst==s & cnt[s]==1`, which is NOT busy.
  - Rationale: the register file writes on the falling edge, so a same-cycle writeback is visible to the read.
- src_hazard = (src0_used & busy_eff(src0)) | (src1_used & busy_eff(src1)).
- dst_full = issue_writes & dst!=15 & cnt[dst]==max & ~(wb_valid & wb_dst==dst).
- stall = issue_valid & (src_hazard | dst_full). Zero latency: stall depends on the same cycle's inputs and current counters.
- inc[i] = issue_accept & issue_writes & issue_dst==i.
- dec[i] = wb_valid & wb_dst==i.
- Counter update at the next edge:
  - inc & ~dec: +1.
  - dec & ~inc: -1.
  - both: unchanged (same register issued and written back in one cycle).
  - neither: unchanged.
- dec with cnt==0 and no inc: counter stays 0, err_underflow set.
- inc with cnt==max and no dec: counter stays max, err_overflow set.
- No wrap-around in either direction.
- flush (without reset): all counters cleared to 0 at the next edge; that cycle's issue and wb are discarded for counting. Errors are not cleared; only reset clears them. stall is still computed normally during the flush cycle.
- busy_mask reflects registered counters only and does not include the same-cycle wb bypass.
- No FSM beyond the counters; the block is purely per-register counter state plus sticky error flags.

Decomposition:
- Shared package holds:
  - REG_COUNT=16
  - PC_REG=4'd15
  - default CNT_W=2
  - function `reg_is_tracked(idx)` returning idx!=PC_REG
- Sub-module `scoreboard_counter` (CNT_W): one saturating up/down counter.
  - Inputs: inc, dec, clr.
  - Outputs: count, nonzero, at_max, underflow_pulse, overflow_pulse.
  - Instantiated 15 times in a generate loop; the top holds the decode, stall logic and sticky errors.

Test Plan:
- Reset, then issue dst=R3 (writes, no sources) -> busy_mask=16'h0008 next cycle, stall=0.
- RAW: after the above, issue src0=R3 used, no wb -> stall=1, issue_accept=0. Next cycle wb_valid=1, wb_dst=R3 with the same issue -> stall=0 that cycle; busy_mask=0 after the edge.
- Saturation: CNT_W=2, issue dst=R5 three times with no wb -> cnt[5]=3. Fourth issue dst=R5 -> stall=1. Fourth issue plus same-cycle wb_dst=R5 -> stall=0, cnt stays 3.
- R15: issue src0=15, dst=15, and wb_dst=15 repeatedly -> stall=0, busy_mask[15]=0, no errors.
- Underflow: after reset, wb_valid=1, wb_dst=R7 -> err_underflow=1 next cycle and stays 1; cnt[7]=0. Only reset clears the flag.
- Flush: R1, R2, R4 pending (busy_mask=16'h0016) plus a simultaneous issue dst=R9 and flush=1 -> busy_mask=0 next cycle.
- Reset mid-operation: counters pending, reset=1 together with issue/wb/flush -> all state 0 next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_pkg
// Description : Shared constants and helpers for the register-file scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

    localparam int         REG_COUNT     = 16;
    localparam logic [3:0] PC_REG        = 4'd15;
    localparam int         DEFAULT_CNT_W = 2;

    // R15 carries the externally supplied PC and never participates in hazards.
    function automatic logic reg_is_tracked(input logic [3:0] idx);
        return idx != PC_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_counter
// Description : Saturating up/down pending-write counter for one register.
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow_pulse,
    output logic             overflow_pulse
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic             w_up;
    logic             w_down;

    // A simultaneous inc and dec cancel, so only the one-sided cases move the count.
    assign w_up    = inc & ~dec;
    assign w_down  = dec & ~inc;
    assign count   = r_count;
    assign nonzero = (r_count != '0);
    assign at_max  = (r_count == c_cnt_max);

    // A flushed cycle is discarded entirely, including its error attempts.
    assign underflow_pulse = ~clr & w_down & ~nonzero;
    assign overflow_pulse  = ~clr & w_up & at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_up && !at_max) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_down && nonzero) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Issue-stage RAW / pending-write hazard controller for R0-R14.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [3:0]           issue_src0,
    input  logic                 issue_src0_used,
    input  logic [3:0]           issue_src1,
    input  logic                 issue_src1_used,
    input  logic [3:0]           issue_dst,
    input  logic                 issue_writes,
    input  logic                 wb_valid,
    input  logic [3:0]           wb_dst,
    input  logic                 flush,
    output logic                 stall,
    output logic                 issue_accept,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 err_underflow,
    output logic                 err_overflow
);

    logic [CNT_W-1:0]     w_cnt [REG_COUNT];
    logic [REG_COUNT-1:0] w_nonzero;
    logic [REG_COUNT-1:0] w_at_max;
    logic [REG_COUNT-1:0] w_uf;
    logic [REG_COUNT-1:0] w_of;
    logic                 w_src0_busy;
    logic                 w_src1_busy;
    logic                 w_dst_full;
    logic                 r_err_underflow;
    logic                 r_err_overflow;

    generate
        for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
            if (i != int'(PC_REG)) begin : g_tracked
                scoreboard_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk             (clk),
                    .rst             (reset),
                    .inc             (issue_accept & issue_writes & (issue_dst == 4'(i))),
                    .dec             (wb_valid & (wb_dst == 4'(i))),
                    .clr             (flush),
                    .count           (w_cnt[i]),
                    .nonzero         (w_nonzero[i]),
                    .at_max          (w_at_max[i]),
                    .underflow_pulse (w_uf[i]),
                    .overflow_pulse  (w_of[i])
                );
            end else begin : g_pc
                // Tie-offs keep the PC slot permanently idle so indexing by 15 is harmless.
                assign w_cnt[i]     = '0;
                assign w_nonzero[i] = 1'b0;
                assign w_at_max[i]  = 1'b0;
                assign w_uf[i]      = 1'b0;
                assign w_of[i]      = 1'b0;
            end
        end
    endgenerate

    // The register file writes on the falling edge, so a final pending write
    // landing this cycle is already visible to the reader.
    assign w_src0_busy = issue_src0_used & reg_is_tracked(issue_src0) & w_nonzero[issue_src0]
                       & ~(wb_valid & (wb_dst == issue_src0) & (w_cnt[issue_src0] == CNT_W'(1)));
    assign w_src1_busy = issue_src1_used & reg_is_tracked(issue_src1) & w_nonzero[issue_src1]
                       & ~(wb_valid & (wb_dst == issue_src1) & (w_cnt[issue_src1] == CNT_W'(1)));
    assign w_dst_full  = issue_writes & reg_is_tracked(issue_dst) & w_at_max[issue_dst]
                       & ~(wb_valid & (wb_dst == issue_dst));

    assign stall         = issue_valid & (w_src0_busy | w_src1_busy | w_dst_full);
    assign issue_accept  = issue_valid & ~stall;
    assign busy_mask     = w_nonzero;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_err_underflow <= r_err_underflow | (|w_uf);
            r_err_overflow  <= r_err_overflow | (|w_of);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench with a per-register pending-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  issue_src0;
    logic        issue_src0_used;
    logic [3:0]  issue_src1;
    logic        issue_src1_used;
    logic [3:0]  issue_dst;
    logic        issue_writes;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic        flush;
    logic        stall;
    logic        issue_accept;
    logic [15:0] busy_mask;
    logic        err_underflow;
    logic        err_overflow;

    int total = 0;
    int bad   = 0;

    int m_cnt [16];
    bit m_unf;
    bit m_ovf;

    regfile_scoreboard #(.CNT_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_src0      (issue_src0),
        .issue_src0_used (issue_src0_used),
        .issue_src1      (issue_src1),
        .issue_src1_used (issue_src1_used),
        .issue_dst       (issue_dst),
        .issue_writes    (issue_writes),
        .wb_valid        (wb_valid),
        .wb_dst          (wb_dst),
        .flush           (flush),
        .stall           (stall),
        .issue_accept    (issue_accept),
        .busy_mask       (busy_mask),
        .err_underflow   (err_underflow),
        .err_overflow    (err_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_busy(int s);
        if (s == 15 || m_cnt[s] == 0) return 1'b0;
        return !(wb_valid && int'(wb_dst) == s && m_cnt[s] == 1);
    endfunction

    function automatic bit m_stall();
        bit hz;
        hz = (issue_src0_used && m_busy(int'(issue_src0))) ||
             (issue_src1_used && m_busy(int'(issue_src1)));
        if (issue_writes && issue_dst != 4'd15 && m_cnt[issue_dst] == MAXC &&
            !(wb_valid && wb_dst == issue_dst))
            hz = 1'b1;
        return issue_valid && hz;
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 15; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    function automatic void m_step();
        bit acc;
        acc = issue_valid && !m_stall();
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_unf = 0;
            m_ovf = 0;
        end else if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                bit up, dn;
                up = acc && issue_writes && int'(issue_dst) == i;
                dn = wb_valid && int'(wb_dst) == i;
                if (up && !dn) begin
                    if (m_cnt[i] == MAXC) m_ovf = 1; else m_cnt[i]++;
                end else if (dn && !up) begin
                    if (m_cnt[i] == 0) m_unf = 1; else m_cnt[i]--;
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic idle();
        reset = 0; issue_valid = 0; issue_src0 = 0; issue_src0_used = 0;
        issue_src1 = 0; issue_src1_used = 0; issue_dst = 0; issue_writes = 0;
        wb_valid = 0; wb_dst = 0; flush = 0;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit wr, input int s0, input bit u0);
        issue_valid = 1; issue_dst = 4'(d); issue_writes = wr;
        issue_src0 = 4'(s0); issue_src0_used = u0; issue_src1_used = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (busy_mask !== 16'h0000 || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: mask=%h unf=%b ovf=%b want 0000 0 0", busy_mask, err_underflow, err_overflow);
        end
    endtask

    task automatic test_raw();
        do_reset();
        issue(3, 1, 0, 0); #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL raw_first_stall: got %b want 0", stall); end
        tick(); idle();
        total++;
        if (busy_mask !== 16'h0008) begin bad++; $display("FAIL raw_mask_r3: got %h want 0008", busy_mask); end
        issue(0, 0, 3, 1); #1;
        total++;
        if (stall !== 1'b1 || issue_accept !== 1'b0) begin
            bad++; $display("FAIL raw_hazard: stall=%b acc=%b want 1 0", stall, issue_accept);
        end
        tick();
        wb_valid = 1; wb_dst = 4'd3; #1;
        total++;
        if (stall !== 1'b0 || issue_accept !== 1'b1) begin
            bad++; $display("FAIL raw_wb_bypass: stall=%b acc=%b want 0 1", stall, issue_accept);
        end
        tick(); idle();
        total++;
        if (busy_mask !== 16'h0000) begin bad++; $display("FAIL raw_mask_clear: got %h want 0000", busy_mask); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(5, 1, 0, 0); #1;
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL sat_fill%0d: stall=%b want 0", k, stall); end
            tick();
        end
        issue(5, 1, 0, 0); #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL sat_full: stall=%b want 1", stall); end
        wb_valid = 1; wb_dst = 4'd5; #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL sat_full_wb: stall=%b want 0", stall); end
        tick();
        wb_valid = 0; #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL sat_still_max: stall=%b want 1", stall); end
        idle(); #1;
        total++;
        if (busy_mask !== 16'h0020 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL sat_state: mask=%h ovf=%b want 0020 0", busy_mask, err_overflow);
        end
    endtask

    task automatic test_r15();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(15, 1, 15, 1);
            issue_src1 = 4'd15; issue_src1_used = 1;
            wb_valid = 1; wb_dst = 4'd15; #1;
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL r15_stall%0d: got %b want 0", k, stall); end
            tick();
        end
        idle();
        total++;
        if (busy_mask !== 16'h0000 || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL r15_state: mask=%h unf=%b ovf=%b want 0000 0 0", busy_mask, err_underflow, err_overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        wb_valid = 1; wb_dst = 4'd7; tick(); idle();
        total++;
        if (err_underflow !== 1'b1 || busy_mask !== 16'h0000) begin
            bad++; $display("FAIL underflow_set: unf=%b mask=%h want 1 0000", err_underflow, busy_mask);
        end
        flush = 1; tick(); idle(); tick();
        total++;
        if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
        do_reset();
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL underflow_reset: got %b want 0", err_underflow); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 1, 0, 0); tick();
        issue(2, 1, 0, 0); tick();
        issue(4, 1, 0, 0); tick();
        idle(); #1;
        total++;
        if (busy_mask !== 16'h0016) begin bad++; $display("FAIL flush_pre: got %h want 0016", busy_mask); end
        issue(9, 1, 0, 0); flush = 1; tick(); idle();
        total++;
        if (busy_mask !== 16'h0000) begin bad++; $display("FAIL flush_clear: got %h want 0000", busy_mask); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(6, 1, 0, 0); tick();
        wb_valid = 1; wb_dst = 4'd8; tick(); idle();
        total++;
        if (busy_mask !== 16'h0040 || err_underflow !== 1'b1) begin
            bad++; $display("FAIL rmid_pre: mask=%h unf=%b want 0040 1", busy_mask, err_underflow);
        end
        issue(10, 1, 0, 0); wb_valid = 1; wb_dst = 4'd2; flush = 1; reset = 1;
        tick(); idle();
        total++;
        if (busy_mask !== 16'h0000 || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            bad++; $display("FAIL rmid_state: mask=%h unf=%b ovf=%b want 0000 0 0", busy_mask, err_underflow, err_overflow);
        end
    endtask

    // Small register window to make collisions and hazards frequent.
    function automatic logic [3:0] pick();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            flush           = ($urandom_range(0, 39) == 0);
            issue_valid     = $urandom_range(0, 3) != 0;
            issue_src0      = pick();
            issue_src0_used = $urandom_range(0, 1);
            issue_src1      = pick();
            issue_src1_used = $urandom_range(0, 1);
            issue_dst       = pick();
            issue_writes    = $urandom_range(0, 3) != 0;
            wb_valid        = $urandom_range(0, 2) == 0;
            wb_dst          = pick();
            #1;
            total++;
            if (stall !== m_stall() || issue_accept !== (issue_valid && !m_stall())) begin
                bad++; $display("FAIL rnd_stall@%0d: stall=%b acc=%b want %b %b", n, stall, issue_accept,
                                m_stall(), issue_valid && !m_stall());
            end
            tick();
            total++;
            if (busy_mask !== m_mask() || err_underflow !== m_unf || err_overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_state@%0d: mask=%h unf=%b ovf=%b want %h %b %b", n, busy_mask,
                                err_underflow, err_overflow, m_mask(), m_unf, m_ovf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_unf = 0;
        m_ovf = 0;
        @(negedge clk);
        test_reset();
        test_raw();
        test_saturation();
        test_r15();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
